// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter sharing one streaming FFT core between two requesters.
// Optional per-consumer frame counters are enabled with `define FFT_ARB_STATS_EN.
module fft_frame_arbiter #(
  parameter int SIZE_BUFFER    = 4,
  parameter int DATA_FFT_SIZE  = 16,
  parameter int TAG_DEPTH_LOG2 = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req0_valid,
  input  logic [DATA_FFT_SIZE-1:0] i_req0_i,
  input  logic [DATA_FFT_SIZE-1:0] i_req0_q,
  output logic                     o_req0_ready,
  input  logic                     i_req1_valid,
  input  logic [DATA_FFT_SIZE-1:0] i_req1_i,
  input  logic [DATA_FFT_SIZE-1:0] i_req1_q,
  output logic                     o_req1_ready,
  output logic                     o_fft_in_valid,
  output logic [DATA_FFT_SIZE-1:0] o_fft_in_i,
  output logic [DATA_FFT_SIZE-1:0] o_fft_in_q,
  input  logic                     i_fft_in_ready,
  input  logic                     i_fft_out_valid,
  input  logic [DATA_FFT_SIZE-1:0] i_fft_out_i,
  input  logic [DATA_FFT_SIZE-1:0] i_fft_out_q,
  output logic                     o_fft_out_ready,
  output logic                     o_res0_valid,
  output logic [DATA_FFT_SIZE-1:0] o_res0_i,
  output logic [DATA_FFT_SIZE-1:0] o_res0_q,
  input  logic                     i_res0_ready,
  output logic                     o_res1_valid,
  output logic [DATA_FFT_SIZE-1:0] o_res1_i,
  output logic [DATA_FFT_SIZE-1:0] o_res1_q,
  input  logic                     i_res1_ready,
  output logic                     o_grant,
  output logic                     o_busy,
`ifdef FFT_ARB_STATS_EN
  output logic [15:0]              o_frames0,
  output logic [15:0]              o_frames1,
`endif
  output logic                     o_err_orphan
);

  localparam int TAG_DEPTH = 1 << TAG_DEPTH_LOG2;

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t                    r_state;
  logic                      r_grant;
  logic                      r_last_grant;
  logic                      r_busy;
  logic                      r_err_orphan;
  logic [SIZE_BUFFER-1:0]    r_in_cnt;
  logic [SIZE_BUFFER-1:0]    r_out_cnt;
  logic [TAG_DEPTH-1:0]      r_tag_mem;
  logic [TAG_DEPTH_LOG2-1:0] r_tag_wr;
  logic [TAG_DEPTH_LOG2-1:0] r_tag_rd;
  logic [TAG_DEPTH_LOG2:0]   r_tag_cnt;

  logic w_tag_empty;
  logic w_tag_full;
  logic w_tag_head;
  logic w_grant_next;
  logic w_push;
  logic w_pop;
  logic w_in_fire;
  logic w_out_fire;

  assign w_tag_empty  = (r_tag_cnt == '0);
  assign w_tag_full   = (r_tag_cnt == (TAG_DEPTH_LOG2 + 1)'(TAG_DEPTH));
  assign w_tag_head   = r_tag_mem[r_tag_rd];
  // Contention flips away from the last winner; a lone requester always wins.
  assign w_grant_next = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
  assign w_push       = (r_state == ST_IDLE) & ~w_tag_full & (i_req0_valid | i_req1_valid);
  assign w_in_fire    = o_fft_in_valid & i_fft_in_ready;
  assign w_out_fire   = i_fft_out_valid & o_fft_out_ready;
  assign w_pop        = w_out_fire & (&r_out_cnt);

  // NOTE: every output gets a default before the case logic so no latch is inferred.
  always_comb begin
    o_fft_in_valid = 1'b0;
    o_fft_in_i     = '0;
    o_fft_in_q     = '0;
    o_req0_ready   = 1'b0;
    o_req1_ready   = 1'b0;
    if (r_state == ST_STREAM) begin
      if (r_grant) begin
        o_fft_in_valid = i_req1_valid;
        o_fft_in_i     = i_req1_i;
        o_fft_in_q     = i_req1_q;
        o_req1_ready   = i_fft_in_ready;
      end else begin
        o_fft_in_valid = i_req0_valid;
        o_fft_in_i     = i_req0_i;
        o_fft_in_q     = i_req0_q;
        o_req0_ready   = i_fft_in_ready;
      end
    end
  end

  always_comb begin
    o_fft_out_ready = 1'b0;
    o_res0_valid    = 1'b0;
    o_res0_i        = '0;
    o_res0_q        = '0;
    o_res1_valid    = 1'b0;
    o_res1_i        = '0;
    o_res1_q        = '0;
    if (!w_tag_empty) begin
      o_fft_out_ready = w_tag_head ? i_res1_ready : i_res0_ready;
      if (i_fft_out_valid) begin
        if (w_tag_head) begin
          o_res1_valid = 1'b1;
          o_res1_i     = i_fft_out_i;
          o_res1_q     = i_fft_out_q;
        end else begin
          o_res0_valid = 1'b1;
          o_res0_i     = i_fft_out_i;
          o_res0_q     = i_fft_out_q;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_in_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state      <= ST_STREAM;
            r_busy       <= 1'b1;
            r_grant      <= w_grant_next;
            r_last_grant <= w_grant_next;
          end
        end
        ST_STREAM: begin
          if (w_in_fire) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            if (&r_in_cnt) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: tag storage is not reset; the occupancy counter alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_tag_mem[r_tag_wr] <= w_grant_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tag_wr     <= '0;
      r_tag_rd     <= '0;
      r_tag_cnt    <= '0;
      r_out_cnt    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) r_tag_wr <= r_tag_wr + 1'b1;
      if (w_pop)  r_tag_rd <= r_tag_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
        2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
        default: r_tag_cnt <= r_tag_cnt;
      endcase
      if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
      if (w_tag_empty && i_fft_out_valid) r_err_orphan <= 1'b1;
    end
  end

`ifdef FFT_ARB_STATS_EN
  logic [15:0] r_frames0;
  logic [15:0] r_frames1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frames0 <= '0;
      r_frames1 <= '0;
    end else if (w_pop) begin
      if (w_tag_head) r_frames1 <= r_frames1 + 1'b1;
      else            r_frames0 <= r_frames0 + 1'b1;
    end
  end

  assign o_frames0 = r_frames0;
  assign o_frames1 = r_frames1;
`endif

  assign o_grant      = r_grant;
  assign o_busy       = r_busy;
  assign o_err_orphan = r_err_orphan;

endmodule
